// File: rtl/arm_ctrl_seq.sv
// arm_ctrl_seq: ID-stage control unit for the ARM pipeline.
// Decodes mode/op_code/s into the execute command and the memory, write-back
// and branch controls, and holds them in an ID/EX control register that
// supports freeze and flush. With ARM_CTRL_BLOCK_XFER_EN defined, LDM/STM
// block transfers are split into one memory beat per cycle. Each beat walks
// the register list from the lowest set bit upward, and busy holds the
// front end until the sequence ends.
//
// Ports:
//   clk, rst (synchronous, active-low)
//   valid_in, mode[1:0], op_code[3:0], s, cond_pass : decoded instruction
//   block, reg_list[NREGS-1:0]                      : block-transfer request
//   freeze, flush                                   : pipeline hold / squash
//   busy                                            : sequencer occupied
//   out_valid, exe_cmd[3:0], mem_r_en, mem_w_en,
//   wb_en, b, s_out                                 : registered controls
//   xfer_reg[RIDX_W-1:0], xfer_off[OFF_W-1:0], last : current beat
//
// Build option: ARM_CTRL_BLOCK_XFER_EN enables block-transfer sequencing.
// When it is not defined, block and reg_list are ignored and busy and xfer_*
// stay at 0.
module arm_ctrl_seq #(
  parameter int unsigned NREGS  = 16,
  parameter int unsigned RIDX_W = $clog2(NREGS),
  parameter int unsigned OFF_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [1:0]        mode,
  input  logic [3:0]        op_code,
  input  logic              s,
  input  logic              cond_pass,
  input  logic              block,
  input  logic [NREGS-1:0]  reg_list,
  input  logic              freeze,
  input  logic              flush,
  output logic              busy,
  output logic              out_valid,
  output logic [3:0]        exe_cmd,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              wb_en,
  output logic              b,
  output logic              s_out,
  output logic [RIDX_W-1:0] xfer_reg,
  output logic [OFF_W-1:0]  xfer_off,
  output logic              last
);

  localparam logic [3:0] CMD_BLOCK = 4'b0010;

  logic              busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic [3:0]        exe_cmd_q, exe_cmd_d;
  logic              mem_r_en_q, mem_r_en_d;
  logic              mem_w_en_q, mem_w_en_d;
  logic              wb_en_q, wb_en_d;
  logic              b_q, b_d;
  logic              s_out_q, s_out_d;
  logic [RIDX_W-1:0] xfer_reg_q, xfer_reg_d;
  logic [OFF_W-1:0]  xfer_off_q, xfer_off_d;
  logic              last_q, last_d;

`ifdef ARM_CTRL_BLOCK_XFER_EN
  typedef enum logic [0:0] {S_IDLE, S_BLOCK} state_e;
  state_e            state_q, state_d;
  logic [NREGS-1:0]  rem_q, rem_d;
  logic [RIDX_W-1:0] k_q, k_d;
  logic              blk_l_q, blk_l_d;

  // Index of the lowest set bit of v.
  function automatic logic [RIDX_W-1:0] lsb_idx(input logic [NREGS-1:0] v);
    logic [RIDX_W-1:0] r;
    r = '0;
    for (int i = int'(NREGS) - 1; i >= 0; i--) begin
      if (v[i]) r = RIDX_W'(i);
    end
    return r;
  endfunction
`else
  logic unused_blk;
  assign unused_blk = block ^ (^reg_list);
`endif

  // Combinational decode of the presented instruction.
  logic [3:0] dec_cmd;
  logic       dec_mr, dec_mw, dec_wb, dec_b, dec_s, dec_cmp_tst;
  always_comb begin
    dec_cmd = 4'b0000;
    if (mode == 2'b00 || mode == 2'b01) begin
      case (op_code)
        4'b1101: dec_cmd = 4'b0001;
        4'b1111: dec_cmd = 4'b1001;
        4'b0100: dec_cmd = 4'b0010;
        4'b0101: dec_cmd = 4'b0011;
        4'b0010: dec_cmd = 4'b0100;
        4'b0110: dec_cmd = 4'b0101;
        4'b0000: dec_cmd = 4'b0110;
        4'b1100: dec_cmd = 4'b0111;
        4'b0001: dec_cmd = 4'b1000;
        4'b1010: dec_cmd = 4'b0100;
        4'b1000: dec_cmd = 4'b0110;
        default: dec_cmd = 4'b0000;
      endcase
    end
    dec_cmp_tst = (op_code == 4'b1010) || (op_code == 4'b1000);
    dec_b  = (mode == 2'b10);
    dec_mr = (mode == 2'b01) && s;
    dec_mw = (mode == 2'b01) && !s;
    if (mode == 2'b01 || mode == 2'b10) dec_s = 1'b0;
    else if (dec_cmp_tst)               dec_s = 1'b1;
    else                                dec_s = s;
    dec_wb = !(dec_b || dec_mw || (mode == 2'b00 && dec_cmp_tst));
  end

  // Next-state: hold by default; any non-frozen (or flushed) edge reloads the
  // control register, starting from a bubble and overriding as needed.
  always_comb begin
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    exe_cmd_d   = exe_cmd_q;
    mem_r_en_d  = mem_r_en_q;
    mem_w_en_d  = mem_w_en_q;
    wb_en_d     = wb_en_q;
    b_d         = b_q;
    s_out_d     = s_out_q;
    xfer_reg_d  = xfer_reg_q;
    xfer_off_d  = xfer_off_q;
    last_d      = last_q;
`ifdef ARM_CTRL_BLOCK_XFER_EN
    state_d = state_q;
    rem_d   = rem_q;
    k_d     = k_q;
    blk_l_d = blk_l_q;
`endif
    if (flush || !freeze) begin
      out_valid_d = 1'b0;
      exe_cmd_d   = 4'b0000;
      mem_r_en_d  = 1'b0;
      mem_w_en_d  = 1'b0;
      wb_en_d     = 1'b0;
      b_d         = 1'b0;
      s_out_d     = 1'b0;
      xfer_reg_d  = '0;
      xfer_off_d  = '0;
      last_d      = 1'b0;
`ifdef ARM_CTRL_BLOCK_XFER_EN
      if (flush) begin
        state_d = S_IDLE;
        rem_d   = '0;
        k_d     = '0;
      end else if (state_q == S_BLOCK) begin
        // Mid-sequence beat: inputs ignored, direction from the latched L bit.
        out_valid_d = 1'b1;
        exe_cmd_d   = CMD_BLOCK;
        mem_r_en_d  = blk_l_q;
        wb_en_d     = blk_l_q;
        mem_w_en_d  = !blk_l_q;
        xfer_reg_d  = lsb_idx(rem_q);
        xfer_off_d  = OFF_W'({k_q, 2'b00});
        rem_d       = rem_q & (rem_q - NREGS'(1));
        k_d         = k_q + RIDX_W'(1);
        if (rem_d == '0) begin
          last_d  = 1'b1;
          state_d = S_IDLE;
          k_d     = '0;
        end
      end else if (valid_in && cond_pass) begin
        if (mode == 2'b01 && block) begin
          if (reg_list != '0) begin
            out_valid_d = 1'b1;
            exe_cmd_d   = CMD_BLOCK;
            mem_r_en_d  = s;
            wb_en_d     = s;
            mem_w_en_d  = !s;
            xfer_reg_d  = lsb_idx(reg_list);
            blk_l_d     = s;
            rem_d       = reg_list & (reg_list - NREGS'(1));
            if (rem_d == '0) begin
              last_d = 1'b1;
            end else begin
              k_d     = RIDX_W'(1);
              state_d = S_BLOCK;
            end
          end
        end else begin
          out_valid_d = 1'b1;
          exe_cmd_d   = dec_cmd;
          mem_r_en_d  = dec_mr;
          mem_w_en_d  = dec_mw;
          wb_en_d     = dec_wb;
          b_d         = dec_b;
          s_out_d     = dec_s;
          last_d      = 1'b1;
        end
      end
`else
      if (!flush && valid_in && cond_pass) begin
        out_valid_d = 1'b1;
        exe_cmd_d   = dec_cmd;
        mem_r_en_d  = dec_mr;
        mem_w_en_d  = dec_mw;
        wb_en_d     = dec_wb;
        b_d         = dec_b;
        s_out_d     = dec_s;
        last_d      = 1'b1;
      end
`endif
    end
`ifdef ARM_CTRL_BLOCK_XFER_EN
    busy_d = (state_d == S_BLOCK);
`else
    busy_d = 1'b0;
`endif
  end

  // Control register and sequencer state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      exe_cmd_q   <= 4'b0000;
      mem_r_en_q  <= 1'b0;
      mem_w_en_q  <= 1'b0;
      wb_en_q     <= 1'b0;
      b_q         <= 1'b0;
      s_out_q     <= 1'b0;
      xfer_reg_q  <= '0;
      xfer_off_q  <= '0;
      last_q      <= 1'b0;
`ifdef ARM_CTRL_BLOCK_XFER_EN
      state_q <= S_IDLE;
      rem_q   <= '0;
      k_q     <= '0;
      blk_l_q <= 1'b0;
`endif
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      exe_cmd_q   <= exe_cmd_d;
      mem_r_en_q  <= mem_r_en_d;
      mem_w_en_q  <= mem_w_en_d;
      wb_en_q     <= wb_en_d;
      b_q         <= b_d;
      s_out_q     <= s_out_d;
      xfer_reg_q  <= xfer_reg_d;
      xfer_off_q  <= xfer_off_d;
      last_q      <= last_d;
`ifdef ARM_CTRL_BLOCK_XFER_EN
      state_q <= state_d;
      rem_q   <= rem_d;
      k_q     <= k_d;
      blk_l_q <= blk_l_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign exe_cmd   = exe_cmd_q;
  assign mem_r_en  = mem_r_en_q;
  assign mem_w_en  = mem_w_en_q;
  assign wb_en     = wb_en_q;
  assign b         = b_q;
  assign s_out     = s_out_q;
  assign xfer_reg  = xfer_reg_q;
  assign xfer_off  = xfer_off_q;
  assign last      = last_q;

endmodule

// File: tb/tb_arm_ctrl_seq.sv
// Directed testbench for arm_ctrl_seq: decode map, bubbles, block-transfer
// sequencing (when ARM_CTRL_BLOCK_XFER_EN is defined), freeze, flush and
// reset. Expected values are written out by hand per vector.
module tb_arm_ctrl_seq;

  localparam int unsigned NREGS  = 16;
  localparam int unsigned RIDX_W = 4;
  localparam int unsigned OFF_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_in;
  logic [1:0]        mode;
  logic [3:0]        op_code;
  logic              s;
  logic              cond_pass;
  logic              block;
  logic [NREGS-1:0]  reg_list;
  logic              freeze;
  logic              flush;
  logic              busy;
  logic              out_valid;
  logic [3:0]        exe_cmd;
  logic              mem_r_en;
  logic              mem_w_en;
  logic              wb_en;
  logic              b;
  logic              s_out;
  logic [RIDX_W-1:0] xfer_reg;
  logic [OFF_W-1:0]  xfer_off;
  logic              last;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  arm_ctrl_seq #(.NREGS(NREGS), .RIDX_W(RIDX_W), .OFF_W(OFF_W)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mode(mode), .op_code(op_code),
    .s(s), .cond_pass(cond_pass), .block(block), .reg_list(reg_list),
    .freeze(freeze), .flush(flush), .busy(busy), .out_valid(out_valid),
    .exe_cmd(exe_cmd), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en),
    .b(b), .s_out(s_out), .xfer_reg(xfer_reg), .xfer_off(xfer_off), .last(last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare every output against one hand-written expectation.
  task automatic chk_o(input string tag, input logic ev, input logic [3:0] ecmd,
                       input logic emr, input logic emw, input logic ewb,
                       input logic eb, input logic es, input logic elast,
                       input logic ebusy, input logic [3:0] ereg,
                       input logic [7:0] eoff);
    chk({tag, ".valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".cmd"},   32'(exe_cmd),   32'(ecmd));
    chk({tag, ".mr"},    32'(mem_r_en),  32'(emr));
    chk({tag, ".mw"},    32'(mem_w_en),  32'(emw));
    chk({tag, ".wb"},    32'(wb_en),     32'(ewb));
    chk({tag, ".b"},     32'(b),         32'(eb));
    chk({tag, ".s"},     32'(s_out),     32'(es));
    chk({tag, ".last"},  32'(last),      32'(elast));
    chk({tag, ".busy"},  32'(busy),      32'(ebusy));
    chk({tag, ".reg"},   32'(xfer_reg),  32'(ereg));
    chk({tag, ".off"},   32'(xfer_off),  32'(eoff));
  endtask

  task automatic ins(input logic v, input logic [1:0] m, input logic [3:0] op,
                     input logic sb, input logic cp, input logic blk,
                     input logic [15:0] rl);
    valid_in  = v;
    mode      = m;
    op_code   = op;
    s         = sb;
    cond_pass = cp;
    block     = blk;
    reg_list  = rl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with random inputs, including freeze and flush.
    rst       = 1'b0;
    valid_in  = 1'($urandom);
    mode      = 2'($urandom);
    op_code   = 4'($urandom);
    s         = 1'($urandom);
    cond_pass = 1'($urandom);
    block     = 1'($urandom);
    reg_list  = 16'($urandom);
    freeze    = 1'($urandom);
    flush     = 1'($urandom);
    tick();
    tick();
    chk_o("reset", 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 8'd0);

    rst = 1'b1; freeze = 1'b0; flush = 1'b0;

    // Single-beat decode.
    ins(1, 2'b00, 4'b0100, 0, 1, 0, 16'h0); tick();
    chk_o("add",    1, 4'b0010, 0, 0, 1, 0, 0, 1, 0, 4'd0, 8'd0);
    ins(1, 2'b00, 4'b1010, 0, 1, 0, 16'h0); tick();
    chk_o("cmp",    1, 4'b0100, 0, 0, 0, 0, 1, 1, 0, 4'd0, 8'd0);
    ins(1, 2'b10, 4'b0000, 0, 1, 0, 16'h0); tick();
    chk_o("branch", 1, 4'b0000, 0, 0, 0, 1, 0, 1, 0, 4'd0, 8'd0);
    ins(1, 2'b00, 4'b1101, 1, 1, 0, 16'h0); tick();
    chk_o("movs",   1, 4'b0001, 0, 0, 1, 0, 1, 1, 0, 4'd0, 8'd0);
    ins(1, 2'b00, 4'b1111, 0, 1, 0, 16'h0); tick();
    chk_o("mvn",    1, 4'b1001, 0, 0, 1, 0, 0, 1, 0, 4'd0, 8'd0);
    ins(1, 2'b00, 4'b0011, 1, 1, 0, 16'h0); tick();
    chk_o("undef",  1, 4'b0000, 0, 0, 1, 0, 1, 1, 0, 4'd0, 8'd0);
    ins(1, 2'b01, 4'b0100, 1, 1, 0, 16'h0); tick();
    chk_o("ldr",    1, 4'b0010, 1, 0, 1, 0, 0, 1, 0, 4'd0, 8'd0);
    ins(1, 2'b01, 4'b0100, 0, 1, 0, 16'h0); tick();
    chk_o("str",    1, 4'b0010, 0, 1, 0, 0, 0, 1, 0, 4'd0, 8'd0);
    ins(1, 2'b01, 4'b0100, 1, 0, 0, 16'h0); tick();
    chk_o("ldr_nc", 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'd0, 8'd0);
    ins(0, 2'b00, 4'b0100, 0, 1, 0, 16'h0); tick();
    chk_o("novalid",0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'd0, 8'd0);

`ifdef ARM_CTRL_BLOCK_XFER_EN
    // LDM 0x8025: regs 0,2,5,15; a queued TST is ignored until the end.
    ins(1, 2'b01, 4'b0100, 1, 1, 1, 16'h8025); tick();
    chk_o("ldm0", 1, 4'b0010, 1, 0, 1, 0, 0, 0, 1, 4'd0, 8'd0);
    ins(1, 2'b00, 4'b1000, 0, 1, 0, 16'h0); tick();
    chk_o("ldm1", 1, 4'b0010, 1, 0, 1, 0, 0, 0, 1, 4'd2, 8'd4);
    tick();
    chk_o("ldm2", 1, 4'b0010, 1, 0, 1, 0, 0, 0, 1, 4'd5, 8'd8);
    tick();
    chk_o("ldm3", 1, 4'b0010, 1, 0, 1, 0, 0, 1, 0, 4'd15, 8'd12);
    tick();
    chk_o("tst",  1, 4'b0110, 0, 0, 0, 0, 1, 1, 0, 4'd0, 8'd0);

    // STM 0x0006 with freeze mid-sequence and after the last beat.
    ins(1, 2'b01, 4'b0100, 0, 1, 1, 16'h0006); tick();
    chk_o("stm0",    1, 4'b0010, 0, 1, 0, 0, 0, 0, 1, 4'd1, 8'd0);
    freeze = 1'b1; ins(1, 2'b00, 4'b0100, 0, 1, 0, 16'h0); tick();
    chk_o("stm0_fz", 1, 4'b0010, 0, 1, 0, 0, 0, 0, 1, 4'd1, 8'd0);
    freeze = 1'b0; tick();
    chk_o("stm1",    1, 4'b0010, 0, 1, 0, 0, 0, 1, 0, 4'd2, 8'd4);
    freeze = 1'b1; tick();
    chk_o("stm1_fz", 1, 4'b0010, 0, 1, 0, 0, 0, 1, 0, 4'd2, 8'd4);
    freeze = 1'b0; tick();
    chk_o("add2",    1, 4'b0010, 0, 0, 1, 0, 0, 1, 0, 4'd0, 8'd0);

    // STM 0x00FF aborted by flush (with freeze) after the third beat.
    ins(1, 2'b01, 4'b0100, 0, 1, 1, 16'h00FF); tick();
    chk_o("stmf0", 1, 4'b0010, 0, 1, 0, 0, 0, 0, 1, 4'd0, 8'd0);
    tick();
    chk_o("stmf1", 1, 4'b0010, 0, 1, 0, 0, 0, 0, 1, 4'd1, 8'd4);
    tick();
    chk_o("stmf2", 1, 4'b0010, 0, 1, 0, 0, 0, 0, 1, 4'd2, 8'd8);
    ins(1, 2'b00, 4'b0100, 0, 1, 0, 16'h0); flush = 1'b1; freeze = 1'b1; tick();
    chk_o("flush", 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'd0, 8'd0);
    flush = 1'b0; freeze = 1'b0; tick();
    chk_o("add3",  1, 4'b0010, 0, 0, 1, 0, 0, 1, 0, 4'd0, 8'd0);

    // Empty register list is a bubble.
    ins(1, 2'b01, 4'b0100, 1, 1, 1, 16'h0000); tick();
    chk_o("ldm_empty", 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'd0, 8'd0);
`else
    // Without sequencing every mode-01 instruction is a single beat.
    ins(1, 2'b01, 4'b0100, 1, 1, 1, 16'h8025); tick();
    chk_o("ldm_1b", 1, 4'b0010, 1, 0, 1, 0, 0, 1, 0, 4'd0, 8'd0);
    ins(1, 2'b00, 4'b1000, 0, 1, 0, 16'h0); tick();
    chk_o("tst",    1, 4'b0110, 0, 0, 0, 0, 1, 1, 0, 4'd0, 8'd0);

    ins(1, 2'b01, 4'b0100, 0, 1, 1, 16'h0006); tick();
    chk_o("stm_1b", 1, 4'b0010, 0, 1, 0, 0, 0, 1, 0, 4'd0, 8'd0);
    freeze = 1'b1; ins(1, 2'b00, 4'b0100, 0, 1, 0, 16'h0); tick();
    chk_o("stm_fz", 1, 4'b0010, 0, 1, 0, 0, 0, 1, 0, 4'd0, 8'd0);
    freeze = 1'b0; tick();
    chk_o("add2",   1, 4'b0010, 0, 0, 1, 0, 0, 1, 0, 4'd0, 8'd0);

    ins(1, 2'b01, 4'b0100, 0, 1, 1, 16'h00FF); tick();
    chk_o("stmf_1b", 1, 4'b0010, 0, 1, 0, 0, 0, 1, 0, 4'd0, 8'd0);
    ins(1, 2'b00, 4'b0100, 0, 1, 0, 16'h0); flush = 1'b1; freeze = 1'b1; tick();
    chk_o("flush",   0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'd0, 8'd0);
    flush = 1'b0; freeze = 1'b0; tick();
    chk_o("add3",    1, 4'b0010, 0, 0, 1, 0, 0, 1, 0, 4'd0, 8'd0);

    // block is ignored, so an empty list still issues the load.
    ins(1, 2'b01, 4'b0100, 1, 1, 1, 16'h0000); tick();
    chk_o("ldm_empty", 1, 4'b0010, 1, 0, 1, 0, 0, 1, 0, 4'd0, 8'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/arm_ctrl_seq.md
# arm_ctrl_seq

Registered, parametrised control unit for the ARM pipeline's ID stage. It decodes `mode`/`op_code`/`s` into the execute command and memory/write-back/branch controls and drives them from an ID/EX control register with freeze and flush. It also sequences block transfers (LDM/STM) into one memory beat per cycle over a parametrised register list, and stalls the front end while a sequence is in progress.

## Interface
Parameters:
- `NREGS`, 16: register-list width and number of architectural registers.
- `RIDX_W`, $clog2(NREGS): register index width.
- `OFF_W`, 8: width of the byte-offset output.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `valid_in`  in  1  decoded instruction present.
- `mode`  in  2  instruction class: 00 data-processing, 01 memory, 10 branch.
- `op_code`  in  4  data-processing opcode.
- `s`  in  1  S bit for mode 00; L bit for mode 01 (1 = load).
- `cond_pass`  in  1  condition check passed.
- `block`  in  1  in mode 01, marks a block transfer.
- `reg_list`  in  NREGS  block-transfer register list.
- `freeze`  in  1  hazard stall; hold everything.
- `flush`  in  1  taken branch; squash.
- `busy`  out  1  sequencer occupied; the front end holds its instruction.
- `out_valid`  out  1  control register holds a live operation.
- `exe_cmd`  out  4  ALU command.
- `mem_r_en`, `mem_w_en`, `wb_en`, `b`, `s_out`  out  1 each  registered controls.
- `xfer_reg`  out  RIDX_W  register index of the current beat.
- `xfer_off`  out  OFF_W  byte offset of the current beat, k*4.
- `last`  out  1  final beat of an operation.

## Operation
Decode for mode 00 and 01 uses this `exe_cmd` map:
- 1101 → 0001
- 1111 → 1001
- 0100 → 0010
- 0101 → 0011
- 0010 → 0100
- 0110 → 0101
- 0000 → 0110
- 1100 → 0111
- 0001 → 1000
- 1010 → 0100
- 1000 → 0110
- any other opcode → 0000
- mode 10 or 11 → 0000

Control outputs:
- `s_out`: 0 in modes 01 and 10; 1 for op_code 1010 or 1000; otherwise `s`.
- `mem_r_en`: mode 01 and `s` = 1.
- `mem_w_en`: mode 01 and `s` = 0.
- `wb_en`: 0 for mode 10, mode-01 stores, and mode-00 CMP/TST; otherwise 1.
- `b`: mode 10.

Bubbles:
- A bubble means `out_valid` and all enables are 0, `exe_cmd` = 0000, and `xfer_*` and `last` are 0.
- An instruction with `valid_in` = 0 or `cond_pass` = 0 loads a bubble.

State machine: IDLE and BLOCK, plus a latched remaining-mask `rem` and a beat counter `k`.
- **IDLE, accept, non-block:** on an edge with `freeze` = 0, the decoded controls load. `last` = 1 and `xfer_reg`/`xfer_off` = 0.
- **IDLE, accept, block:** for mode 01 with `block` = 1:
  - `exe_cmd` = 0010 for every beat.
  - Beat 0 carries the lowest set bit of `reg_list` and `xfer_off` = 0.
  - If popcount = 1: `last` = 1 and the FSM stays in IDLE.
  - If popcount > 1: `rem` = `reg_list` with that bit cleared, `k` = 1, and the FSM goes to BLOCK.
  - An empty `reg_list` loads a bubble.
- **BLOCK:** each non-frozen edge emits the lowest set bit of `rem` with `xfer_off` = k*4, clears that bit and increments `k`. When the emitted bit is the final one, `last` = 1 and the FSM returns to IDLE.
  - Inputs are ignored in BLOCK; op and L bit come from registers latched at accept.
  - `wb_en` = `mem_r_en` = L and `mem_w_en` = !L.
- **`busy`:** registered; 1 exactly while the state is BLOCK.
- **`freeze`:** all registers and state hold.
- **`flush`:** loads a bubble and returns the FSM to IDLE with `rem` = 0, aborting any sequence. `flush` overrides `freeze`.
- **Reset (`rst` = 0):** state IDLE, `rem` = 0, `k` = 0, every output 0. Reset overrides `flush` and `freeze`.

## Timing
- Decode-to-output latency is 1 cycle: fields present before edge T appear on the outputs after T.
- An N-beat block transfer occupies N consecutive non-frozen edges, T to T+N-1.
- `busy` is high from after T until after T+N-1.
- The next instruction is accepted at edge T+N, with no idle cycle between beats or after the last beat.
- Freeze cycles stretch the sequence 1:1.
- `xfer_off` truncates to OFF_W; with defaults the maximum is 60.

## Configuration
- `ARM_CTRL_BLOCK_XFER_EN` defined: block-transfer sequencing as above.
- Not defined:
  - `block` and `reg_list` are ignored.
  - Every mode-01 instruction is single-beat.
  - `busy` is constant 0, `xfer_reg`/`xfer_off` are constant 0, and `last` = `out_valid`.

## Test plan
- Reset: hold `rst` = 0 for 2 edges with random inputs → all outputs 0 and `busy` = 0. Release, then mode 00, op 0100, s 0 → next cycle `exe_cmd` = 0010, `wb_en` = 1, `s_out` = 0.
- CMP: mode 00, op 1010, s 0 → `exe_cmd` = 0100, `s_out` = 1, `wb_en` = 0. Branch: mode 10 → `b` = 1, `wb_en` = 0, `exe_cmd` = 0000.
- LDM, `reg_list` = 0x8025 → beats `xfer_reg` 0, 2, 5, 15 with `xfer_off` 0, 4, 8, 12 and `mem_r_en` = `wb_en` = 1. `busy` is high for 3 cycles and `last` is asserted only on reg 15.
- STM, `reg_list` = 0x0006, with `freeze` on the 2nd cycle → beats reg 1 then reg 2, reg 2 held one extra cycle. `mem_w_en` = 1 and `wb_en` = 0.
- STM 0x00FF with `flush` on beat 3 → next cycle is a bubble, `busy` = 0, and a queued ADD is accepted on the following edge.
- `cond_pass` = 0 for an LDR, and `reg_list` = 0 for an LDM → bubble, all enables 0.
